// File: rtl/m_ram8_dmux.sv
// ---------------------------------------------------------------------------
// m_ram8_dmux -- 8-entry x WIDTH-bit register bank (Hack RAM8 leaf).
//
// Writes are steered to one entry by a one-hot load decoder (m_dmux8way).
// Reads are a combinational 8:1 selection by i_address. A per-entry
// "written" mask records which entries were loaded since reset/clear, and
// o_any is its OR-reduction (m_or8way).
//
// Ports:
//   i_clk      in   1      clock, rising edge
//   i_rst_n    in   1      asynchronous active-low reset
//   i_in       in   WIDTH  write data
//   i_load     in   1      write enable for the addressed entry
//   i_clr      in   1      synchronous clear of entries and written mask
//   i_address  in   3      read/write entry select
//   o_out      out  WIDTH  data of the addressed entry
//   o_written  out  8      bit k set once entry k has been loaded
//   o_any      out  1      OR of o_written
//
// Build option: RAM8_WRITE_BYPASS_EN -- when defined, o_out shows i_in
// combinationally while i_load=1 and i_clr=0 (write-through). Otherwise
// o_out always shows the stored entry.
// ---------------------------------------------------------------------------

module m_dmux8way (
    input  logic       i_in,
    input  logic [2:0] i_sel,
    output logic [7:0] o_out
);
    always_comb begin
        o_out        = '0;
        o_out[i_sel] = i_in;
    end
endmodule

module m_or8way (
    input  logic [7:0] i_in,
    output logic       o_out
);
    assign o_out = |i_in;
endmodule

module m_ram8_dmux #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [2:0]       i_address,
    output logic [WIDTH-1:0] o_out,
    output logic [7:0]       o_written,
    output logic             o_any
);
    logic [WIDTH-1:0] r_mem [8];
    logic [7:0]       r_written;
    logic [7:0]       w_load;
    logic [WIDTH-1:0] w_stored;

    m_dmux8way u_dmux (
        .i_in  (i_load),
        .i_sel (i_address),
        .o_out (w_load)
    );

    // Clear has priority over load; a load in the same cycle is discarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < 8; k++) begin
                r_mem[k] <= '0;
            end
            r_written <= '0;
        end else if (i_clr) begin
            for (int unsigned k = 0; k < 8; k++) begin
                r_mem[k] <= '0;
            end
            r_written <= '0;
        end else begin
            for (int unsigned k = 0; k < 8; k++) begin
                if (w_load[k]) begin
                    r_mem[k]     <= i_in;
                    r_written[k] <= 1'b1;
                end
            end
        end
    end

    assign w_stored = r_mem[i_address];

`ifdef RAM8_WRITE_BYPASS_EN
    // Write-through: the pending write is visible before the edge.
    assign o_out = (i_load && !i_clr) ? i_in : w_stored;
`else
    assign o_out = w_stored;
`endif

    assign o_written = r_written;

    m_or8way u_or (
        .i_in  (r_written),
        .o_out (o_any)
    );
endmodule

// File: tb/tb_m_ram8_dmux.sv
module tb_m_ram8_dmux;
    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        load;
    logic        clr;
    logic [2:0]  addr;
    logic [15:0] dout;
    logic [7:0]  written;
    logic        any_w;

    int total;
    int bad;

    m_ram8_dmux #(.WIDTH(16)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_in      (din),
        .i_load    (load),
        .i_clr     (clr),
        .i_address (addr),
        .o_out     (dout),
        .o_written (written),
        .o_any     (any_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        cl;
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] eo;   // o_out after the edge, load dropped
        logic [7:0]  ew;
        logic        ea;
    } vec_t;

    vec_t vt[$];

    // Reference model: plain arrays following the block's rules.
    logic [15:0] m_mem [8];
    logic        m_wr  [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_mask();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = m_wr[k];
        return r;
    endfunction

    function automatic logic [15:0] m_read(input logic ld, input logic cl,
                                           input logic [2:0] a, input logic [15:0] d);
`ifdef RAM8_WRITE_BYPASS_EN
        if (ld && !cl) return d;
`endif
        return m_mem[a];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 8; k++) begin
            m_mem[k] = '0;
            m_wr[k]  = 1'b0;
        end
    endtask

    task automatic m_edge(input logic ld, input logic cl, input logic [2:0] a, input logic [15:0] d);
        if (cl) m_reset();
        else if (ld) begin
            m_mem[a] = d;
            m_wr[a]  = 1'b1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        load = 1'b1; clr = 1'b0; addr = a; din = d;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; load = 1'b0; clr = 1'b0; addr = '0; din = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vec_t v;
        logic [7:0] mask;
        total = 0; bad = 0;
        rst_n = 1'b1; load = 1'b0; clr = 1'b0; addr = '0; din = '0;

        // ---------------- table-driven directed vectors ----------------
        for (int k = 0; k < 8; k++) begin
            v = '{1'b0, 1'b0, 3'(k), 16'h0, 16'h0000, 8'h00, 1'b0};
            vt.push_back(v);
        end
        mask = 8'h00;
        for (int k = 0; k < 8; k++) begin
            mask[k] = 1'b1;
            v = '{1'b1, 1'b0, 3'(k), 16'h1000 + 16'(k), 16'h1000 + 16'(k), mask, 1'b1};
            vt.push_back(v);
        end
        for (int k = 0; k < 8; k++) begin
            v = '{1'b0, 1'b0, 3'(k), 16'hFFFF, 16'h1000 + 16'(k), 8'hFF, 1'b1};
            vt.push_back(v);
        end
        vt.push_back('{1'b0, 1'b1, 3'd0, 16'h0, 16'h0000, 8'h00, 1'b0});
        vt.push_back('{1'b1, 1'b0, 3'd5, 16'hBEEF, 16'hBEEF, 8'h20, 1'b1});
        vt.push_back('{1'b1, 1'b0, 3'd2, 16'h1234, 16'h1234, 8'h24, 1'b1});
        vt.push_back('{1'b0, 1'b0, 3'd5, 16'h0, 16'hBEEF, 8'h24, 1'b1});
        vt.push_back('{1'b1, 1'b0, 3'd5, 16'h0042, 16'h0042, 8'h24, 1'b1});

        do_reset();
        chk("reset_out", dout, 16'h0);
        chk("reset_written", written, 8'h00);
        chk("reset_any", any_w, 1'b0);

        for (int i = 0; i < vt.size(); i++) begin
            load = vt[i].ld; clr = vt[i].cl; addr = vt[i].a; din = vt[i].d;
            @(posedge clk); #1;
            load = 1'b0; clr = 1'b0;
            #1;
            chk($sformatf("vec%0d_out", i), dout, vt[i].eo);
            chk($sformatf("vec%0d_written", i), written, vt[i].ew);
            chk($sformatf("vec%0d_any", i), any_w, vt[i].ea);
        end

        // ---------------- same-cycle read/write ----------------
        wr(3'd3, 16'h0001);
        load = 1'b1; addr = 3'd3; din = 16'hA5A5;
        #2;
`ifdef RAM8_WRITE_BYPASS_EN
        chk("rw_before", dout, 16'hA5A5);
`else
        chk("rw_before", dout, 16'h0001);
`endif
        @(posedge clk); #1;
        load = 1'b0;
        #1;
        chk("rw_after", dout, 16'hA5A5);

        // ---------------- clear + load on the same edge ----------------
        for (int k = 0; k < 8; k++) wr(3'(k), 16'h1000 + 16'(k));
        clr = 1'b1; load = 1'b1; addr = 3'd6; din = 16'hFFFF;
        #2;
        chk("clrld_before", dout, 16'h1006);
        @(posedge clk); #1;
        clr = 1'b0; load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            addr = 3'(k);
            #1;
            chk($sformatf("clrld_out%0d", k), dout, 16'h0000);
        end
        chk("clrld_written", written, 8'h00);
        chk("clrld_any", any_w, 1'b0);

        // ---------------- asynchronous reset mid-cycle ----------------
        for (int k = 0; k < 8; k++) wr(3'(k), 16'h2000 + 16'(k));
        addr = 3'd4;
        #1;
        chk("arst_pre", dout, 16'h2004);
        rst_n = 1'b0;
        #1;
        chk("arst_out", dout, 16'h0000);
        chk("arst_written", written, 8'h00);
        chk("arst_any", any_w, 1'b0);
        // load on an edge while reset is held is lost
        load = 1'b1; din = 16'h7777;
        @(posedge clk); #1;
        load = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("arst_loadlost", dout, 16'h0000);
        chk("arst_written2", written, 8'h00);

        // ---------------- randomized against the model ----------------
        do_reset();
        m_reset();
        for (int n = 0; n < 400; n++) begin
            logic        rl, rc;
            logic [2:0]  ra;
            logic [15:0] rd;
            rl = ($urandom_range(0, 1) == 1);
            rc = ($urandom_range(0, 15) == 0);
            ra = 3'($urandom_range(0, 7));
            rd = 16'($urandom);
            load = rl; clr = rc; addr = ra; din = rd;
            #3;
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                #1;
                m_reset();
                chk("rnd_arst_out", dout, m_read(rl, rc, ra, rd));
                chk("rnd_arst_written", written, 8'h00);
                rst_n = 1'b1;
            end
            chk("rnd_out", dout, m_read(rl, rc, ra, rd));
            chk("rnd_written", written, m_mask());
            chk("rnd_any", any_w, |m_mask());
            @(posedge clk);
            m_edge(rl, rc, ra, rd);
            #1;
        end
        load = 1'b0; clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            addr = 3'(k);
            #1;
            chk($sformatf("rnd_final%0d", k), dout, m_mem[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
